// File: rtl/fir_out_fifo.sv
// fir_out_fifo: elastic first-word-fall-through output buffer for the FIR engine's
// AXI-Stream master port. It decouples short sink stalls from the FIR, carries tlast
// alongside each sample, and keeps occupancy, sample and frame statistics.
//
// Ports:
//   axis_clk, axis_rst        clock, asynchronous active-high reset
//   clr                       synchronous flush of FIFO and statistics
//   in_tvalid/tdata/tlast     sample stream from the FIR; in_tready back to it
//   out_tvalid/tdata/tlast    head-of-FIFO stream to the sink; out_tready from it
//   level, max_level          current occupancy and high-water mark
//   sample_cnt, frame_cnt     output transfers / output transfers with tlast (wrap)
//   frame_done                one-cycle pulse after each output transfer with tlast
module fir_out_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = $clog2(DEPTH)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   clr,
  input  logic                   in_tvalid,
  input  logic [pDATA_WIDTH-1:0] in_tdata,
  input  logic                   in_tlast,
  output logic                   in_tready,
  output logic                   out_tvalid,
  output logic [pDATA_WIDTH-1:0] out_tdata,
  output logic                   out_tlast,
  input  logic                   out_tready,
  output logic [PTR_W:0]         level,
  output logic [PTR_W:0]         max_level,
  output logic [15:0]            sample_cnt,
  output logic [15:0]            frame_cnt,
  output logic                   frame_done
);

  localparam logic [PTR_W:0] CntFull = (PTR_W+1)'(DEPTH);

  // Payload storage {tlast, data}; deliberately not reset.
  logic [pDATA_WIDTH:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   max_level_q, max_level_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             frame_done_q, frame_done_d;

  logic                 wr, rd;
  logic [pDATA_WIDTH:0] head;

  // No pass-through when full: a read while full frees the slot for the next cycle.
  assign in_tready  = ~axis_rst & ~clr & (count_q != CntFull);
  assign out_tvalid = (count_q != '0);
  assign wr         = in_tvalid & in_tready;
  assign rd         = out_tvalid & out_tready;

  assign head      = mem_q[rd_ptr_q];
  assign out_tdata = out_tvalid ? head[pDATA_WIDTH-1:0] : '0;
  assign out_tlast = out_tvalid & head[pDATA_WIDTH];

  assign level      = count_q;
  assign max_level  = max_level_q;
  assign sample_cnt = sample_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    max_level_d  = max_level_q;
    sample_cnt_d = sample_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;

    if (clr) begin
      // Flush wins over any handshake in the same cycle.
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      max_level_d  = '0;
      sample_cnt_d = '0;
      frame_cnt_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
      if (count_d > max_level_q) max_level_d = count_d;
      if (rd) begin
        sample_cnt_d = sample_cnt_q + 16'd1;
        if (head[pDATA_WIDTH]) begin
          frame_cnt_d  = frame_cnt_q + 16'd1;
          frame_done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      max_level_q  <= '0;
      sample_cnt_q <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      max_level_q  <= max_level_d;
      sample_cnt_q <= sample_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (wr) mem_q[wr_ptr_q] <= {in_tlast, in_tdata};
  end

endmodule

// File: tb/tb_fir_out_fifo.sv
// Self-checking bench for fir_out_fifo: a queue-based reference model predicts every
// output each cycle; directed scenarios plus randomized traffic drive the DUT.
module tb_fir_out_fifo;

  localparam int unsigned Depth = 4;

  logic        clk, rst, clr;
  logic        in_tvalid, in_tlast, in_tready;
  logic [31:0] in_tdata;
  logic        out_tvalid, out_tlast, out_tready;
  logic [31:0] out_tdata;
  logic [2:0]  level, max_level;
  logic [15:0] sample_cnt, frame_cnt;
  logic        frame_done;

  fir_out_fifo #(.pDATA_WIDTH(32), .DEPTH(Depth)) dut (
    .axis_clk   (clk),
    .axis_rst   (rst),
    .clr        (clr),
    .in_tvalid  (in_tvalid),
    .in_tdata   (in_tdata),
    .in_tlast   (in_tlast),
    .in_tready  (in_tready),
    .out_tvalid (out_tvalid),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tready (out_tready),
    .level      (level),
    .max_level  (max_level),
    .sample_cnt (sample_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: FIFO contents as a queue of {tlast, data}, plus statistics.
  logic [32:0] mq[$];
  int unsigned m_max;
  logic [15:0] m_scnt, m_fcnt;
  logic        m_fd;
  logic        acc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_max  = 0;
    m_scnt = '0;
    m_fcnt = '0;
    m_fd   = 1'b0;
  endtask

  // Apply inputs at the falling edge, compare against the model, then advance the model
  // across the next rising edge and wait for the following falling edge.
  task automatic step(input logic tv, input logic [31:0] td, input logic tl,
                      input logic ordy, input logic cl);
    logic        exp_rdy, rd_ev, wr_ev;
    logic [32:0] hd;
    in_tvalid  = tv;
    in_tdata   = td;
    in_tlast   = tl;
    out_tready = ordy;
    clr        = cl;
    #1;
    exp_rdy = !cl && (mq.size() != Depth);
    hd      = (mq.size() != 0) ? mq[0] : 33'd0;
    check_eq("in_tready",  in_tready,  exp_rdy);
    check_eq("out_tvalid", out_tvalid, mq.size() != 0);
    check_eq("out_tdata",  out_tdata,  hd[31:0]);
    check_eq("out_tlast",  out_tlast,  hd[32]);
    check_eq("level",      level,      mq.size());
    check_eq("max_level",  max_level,  m_max);
    check_eq("sample_cnt", sample_cnt, m_scnt);
    check_eq("frame_cnt",  frame_cnt,  m_fcnt);
    check_eq("frame_done", frame_done, m_fd);
    wr_ev = tv && exp_rdy;
    rd_ev = (mq.size() != 0) && ordy;
    acc   = wr_ev;
    if (cl) begin
      model_reset();
    end else begin
      m_fd = rd_ev && hd[32];
      if (rd_ev) begin
        void'(mq.pop_front());
        m_scnt++;
        if (hd[32]) m_fcnt++;
      end
      if (wr_ev) mq.push_back({tl, td});
      if (mq.size() > m_max) m_max = mq.size();
    end
    @(negedge clk);
  endtask

  // Offer one sample until accepted or the try budget runs out (source holds the data).
  task automatic send(input logic [31:0] d, input logic l, input int unsigned pct,
                      input int unsigned tries);
    int unsigned t = 0;
    acc = 1'b0;
    while (!acc && t < tries) begin
      step(1'b1, d, l, ($urandom_range(99) < pct), 1'b0);
      t++;
    end
  endtask

  task automatic idle(input int unsigned n, input logic ordy);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0;
    out_tready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_tready",  in_tready,  1'b0);
    check_eq("rst_out_tvalid", out_tvalid, 1'b0);
    check_eq("rst_level",      level,      3'd0);
    rst = 1'b0;

    // Fill with sink stalled; fifth sample must be held off, then drain in order.
    send(32'h11, 1'b0, 0, 3);
    send(32'h22, 1'b0, 0, 3);
    send(32'h33, 1'b0, 0, 3);
    send(32'h44, 1'b0, 0, 3);
    send(32'h55, 1'b0, 0, 3);
    check_eq("fill_held", acc, 1'b0);
    send(32'h55, 1'b0, 100, 5);
    idle(6, 1'b1);
    check_eq("fill_max", max_level, 3'd4);
    check_eq("fill_cnt", sample_cnt, 16'd5);

    // Streaming with both sides always ready.
    flush();
    for (int unsigned i = 1; i <= 11; i++) send(i, (i == 11), 100, 3);
    idle(3, 1'b1);
    check_eq("stream_scnt", sample_cnt, 16'd11);
    check_eq("stream_fcnt", frame_cnt, 16'd1);
    check_eq("stream_max",  max_level, 3'd1);

    // Simultaneous read/write at level 2, then full with a read.
    flush();
    send(32'hA0, 1'b0, 0, 3);
    send(32'hA1, 1'b0, 0, 3);
    for (int unsigned i = 0; i < 4; i++) send(32'hB0 + i, 1'b0, 100, 3);
    send(32'hC0, 1'b0, 0, 3);
    send(32'hC1, 1'b0, 0, 3);
    send(32'hC2, 1'b0, 0, 3);
    send(32'hC3, 1'b0, 100, 3);
    idle(6, 1'b1);

    // Pointer wrap: three frames of seven samples with a 50% sink.
    flush();
    for (int unsigned f = 0; f < 3; f++)
      for (int unsigned s = 0; s < 7; s++) send($urandom, (s == 6), 50, 50);
    idle(10, 1'b1);
    check_eq("wrap_scnt", sample_cnt, 16'd21);
    check_eq("wrap_fcnt", frame_cnt, 16'd3);

    // Flush at level 3 with handshakes on both sides in the same cycle.
    flush();
    send(32'h1, 1'b1, 0, 3);
    send(32'h2, 1'b0, 0, 3);
    send(32'h3, 1'b1, 0, 3);
    step(1'b1, 32'h4, 1'b0, 1'b1, 1'b1);
    check_eq("clr_level", level, 3'd0);
    send(32'hAA, 1'b0, 0, 3);
    idle(1, 1'b0);
    check_eq("clr_head", out_tdata, 32'hAA);
    idle(2, 1'b1);

    // Asynchronous reset mid-cycle at level 2.
    send(32'h77, 1'b0, 0, 3);
    send(32'h78, 1'b0, 0, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_tvalid", out_tvalid, 1'b0);
    check_eq("arst_out_tdata",  out_tdata,  32'd0);
    check_eq("arst_level",      level,      3'd0);
    check_eq("arst_in_tready",  in_tready,  1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1'b1);
    check_eq("arst_scnt", sample_cnt, 16'd0);

    // Randomized traffic with occasional flushes.
    for (int unsigned i = 0; i < 300; i++) begin
      if ($urandom_range(49) == 0) flush();
      else if ($urandom_range(3) == 0) idle(1, $urandom_range(1));
      else send($urandom, $urandom_range(1), $urandom_range(100), 6);
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
